// File: rtl/dm_access_ctrl_pkg.sv
// Shared types for the MEM-stage data-memory sequencer: op codes, extension codes,
// exception codes and FSM state encoding.
package dm_access_ctrl_pkg;

  typedef enum logic [2:0] {
    OpLw  = 3'd0,
    OpLhu = 3'd1,
    OpLh  = 3'd2,
    OpLbu = 3'd3,
    OpLb  = 3'd4,
    OpSw  = 3'd5,
    OpSh  = 3'd6,
    OpSb  = 3'd7
  } dm_op_e;

  typedef enum logic [3:0] {
    KuoWord  = 4'd0,
    KuoHalfZ = 4'd1,
    KuoHalfS = 4'd2,
    KuoByteZ = 4'd3,
    KuoByteS = 4'd4
  } dm_kuo_e;

  typedef enum logic [1:0] {
    ExcNone = 2'd0,
    ExcAdel = 2'd1,
    ExcAdes = 2'd2,
    ExcBus  = 2'd3
  } dm_exc_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StResp  = 2'd2,
    StFault = 2'd3
  } dm_state_e;

  function automatic logic is_store(dm_op_e op);
    return (op == OpSw) || (op == OpSh) || (op == OpSb);
  endfunction

  function automatic dm_kuo_e op_to_kuo(dm_op_e op);
    dm_kuo_e kuo;
    unique case (op)
      OpLhu:   kuo = KuoHalfZ;
      OpLh:    kuo = KuoHalfS;
      OpLbu:   kuo = KuoByteZ;
      OpLb:    kuo = KuoByteS;
      default: kuo = KuoWord;
    endcase
    return kuo;
  endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Pipeline request, data-memory port, WB hand-off and exception signals of the
// MEM-stage sequencer.
interface dm_access_ctrl_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [1:0]  wb_a;
  logic [3:0]  wb_kuo;
  logic        exc_valid;
  logic [1:0]  exc_code;
  logic [31:0] bad_addr;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
    output stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output wb_valid, wb_data, wb_a, wb_kuo, exc_valid, exc_code, bad_addr
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
    input  stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  wb_valid, wb_data, wb_a, wb_kuo, exc_valid, exc_code, bad_addr
  );
endinterface

// File: rtl/dm_access_ctrl_lane_gen.sv
// Combinational lane generator: alignment check, store byte enables and
// lane-replicated store data from op and the low address bits.
module dm_access_ctrl_lane_gen
  import dm_access_ctrl_pkg::*;
(
  input  dm_op_e      i_op,
  input  logic [1:0]  i_a,
  input  logic [31:0] i_wdata,
  output logic        o_misaligned,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata
);

  always_comb begin
    o_misaligned = 1'b0;
    o_be         = 4'b1111;
    o_wdata      = i_wdata;
    unique case (i_op)
      OpLw, OpSw: o_misaligned = |i_a;
      OpLh, OpLhu: o_misaligned = i_a[0];
      OpSh: begin
        o_misaligned = i_a[0];
        o_be         = i_a[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_wdata[15:0]}};
      end
      OpSb: begin
        o_be    = 4'b0001 << i_a;
        o_wdata = {4{i_wdata[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory sequencer: latches an aligned request, holds the memory
// port until ack or timeout, and emits a WB pulse or an exception pulse.
module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input logic             clk,
  input logic             rst_n,
  dm_access_ctrl_if.slave bus
);

  localparam logic [7:0] CntLast = 8'(WAIT_MAX - 1);

  dm_state_e   r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  dm_op_e      r_op;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_wb_valid;
  logic [31:0] r_wb_data;
  logic [1:0]  r_wb_a;
  dm_kuo_e     r_wb_kuo;
  logic        r_exc_valid;
  dm_exc_e     r_exc_code;
  logic [31:0] r_bad_addr;

  dm_op_e      w_op;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_busy;

  assign w_op = dm_op_e'(bus.req_op);

  dm_access_ctrl_lane_gen u_lane_gen (
    .i_op         (w_op),
    .i_a          (bus.req_addr[1:0]),
    .i_wdata      (bus.req_wdata),
    .o_misaligned (w_misaligned),
    .o_be         (w_be),
    .o_wdata      (w_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_op        <= OpLw;
      r_be        <= '0;
      r_wdata     <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_data   <= '0;
      r_wb_a      <= '0;
      r_wb_kuo    <= KuoWord;
      r_exc_valid <= 1'b0;
      r_exc_code  <= ExcNone;
      r_bad_addr  <= '0;
    end else begin
      r_wb_valid  <= 1'b0;
      r_exc_valid <= 1'b0;
      r_exc_code  <= ExcNone;
      unique case (r_state)
        StIdle: begin
          if (bus.req_valid) begin
            if (w_misaligned) begin
              r_bad_addr  <= bus.req_addr;
              r_exc_valid <= 1'b1;
              r_exc_code  <= is_store(w_op) ? ExcAdes : ExcAdel;
              r_state     <= StFault;
            end else begin
              r_addr  <= bus.req_addr;
              r_op    <= w_op;
              r_be    <= w_be;
              r_wdata <= w_wdata;
              r_cnt   <= '0;
              r_state <= StBusy;
            end
          end
        end
        StBusy: begin
          // Ack takes priority over a timeout reached in the same cycle.
          if (bus.mem_ack) begin
            if (!is_store(r_op)) begin
              r_wb_valid <= 1'b1;
              r_wb_data  <= bus.mem_rdata;
              r_wb_a     <= r_addr[1:0];
              r_wb_kuo   <= op_to_kuo(r_op);
            end
            r_state <= StResp;
          end else if (r_cnt == CntLast) begin
            r_bad_addr  <= r_addr;
            r_exc_valid <= 1'b1;
            r_exc_code  <= ExcBus;
            r_state     <= StFault;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StResp:  r_state <= StIdle;
        StFault: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign w_busy        = (r_state == StBusy);
  assign bus.stall     = ((r_state == StIdle) && bus.req_valid) || w_busy;
  assign bus.mem_req   = w_busy;
  assign bus.mem_we    = w_busy && is_store(r_op);
  assign bus.mem_addr  = {r_addr[31:2], 2'b00};
  assign bus.mem_be    = r_be;
  assign bus.mem_wdata = r_wdata;
  assign bus.wb_valid  = r_wb_valid;
  assign bus.wb_data   = r_wb_data;
  assign bus.wb_a      = r_wb_a;
  assign bus.wb_kuo    = r_wb_kuo;
  assign bus.exc_valid = r_exc_valid;
  assign bus.exc_code  = r_exc_code;
  assign bus.bad_addr  = r_bad_addr;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a wait-state memory responder.
module tb_dm_access_ctrl;

  logic clk;
  logic rst_n;
  dm_access_ctrl_if bus ();

  dm_access_ctrl #(
    .WAIT_MAX (15)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Responder: acks after ack_wait BUSY cycles without ack; ack_force injects a raw pulse.
  int          ack_wait  = 0;
  bit          ack_force = 1'b0;
  int          busy_cnt  = 0;
  logic [31:0] rdata_val = '0;

  always @(posedge clk) busy_cnt <= bus.mem_req ? busy_cnt + 1 : 0;
  assign bus.mem_ack   = ack_force || (bus.mem_req && (busy_cnt == ack_wait));
  assign bus.mem_rdata = rdata_val;

  int          stall_cyc, busy_cyc, wb_cnt, exc_cnt;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata, cap_bad, cap_wb_data;
  logic [3:0]  cap_be, cap_kuo;
  logic [1:0]  cap_code, cap_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Entered shortly after a rising edge; leaves one cycle after the RESP/FAULT cycle.
  task automatic run_access(input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input int wait_n);
    bit done = 1'b0;
    stall_cyc = 0; busy_cyc = 0; wb_cnt = 0; exc_cnt = 0;
    cap_we = 1'b0; cap_addr = '0; cap_wdata = '0; cap_be = '0;
    cap_bad = '0; cap_code = '0; cap_wb_data = '0; cap_a = '0; cap_kuo = '0;
    ack_wait      = wait_n;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.stall) stall_cyc++;
      if (bus.mem_req) begin
        busy_cyc++;
        cap_we    = bus.mem_we;
        cap_addr  = bus.mem_addr;
        cap_be    = bus.mem_be;
        cap_wdata = bus.mem_wdata;
      end
      if (bus.wb_valid) begin
        wb_cnt++;
        cap_wb_data = bus.wb_data;
        cap_a       = bus.wb_a;
        cap_kuo     = bus.wb_kuo;
      end
      if (bus.exc_valid) begin
        exc_cnt++;
        cap_code = bus.exc_code;
        cap_bad  = bus.bad_addr;
      end
      if (!bus.stall && stall_cyc > 0) begin
        done = 1'b1;
        break;
      end
    end
    check("access_done", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    check("rst_exc_valid", 32'(bus.exc_valid), 32'd0);
    check("rst_bad_addr", bus.bad_addr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LW, zero wait
    rdata_val = 32'hDEAD_BEEF;
    run_access(3'd0, 32'h0000_0010, 32'h0, 0);
    check("lw_stall", 32'(stall_cyc), 32'd2);
    check("lw_busy", 32'(busy_cyc), 32'd1);
    check("lw_we", 32'(cap_we), 32'd0);
    check("lw_addr", cap_addr, 32'h10);
    check("lw_be", 32'(cap_be), 32'hF);
    check("lw_wb_cnt", 32'(wb_cnt), 32'd1);
    check("lw_wb_data", cap_wb_data, 32'hDEAD_BEEF);
    check("lw_kuo", 32'(cap_kuo), 32'd0);
    check("lw_a", 32'(cap_a), 32'd0);

    // SH 0x22, three waits
    run_access(3'd6, 32'h0000_0022, 32'h1234_ABCD, 3);
    check("sh_be", 32'(cap_be), 32'hC);
    check("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    check("sh_addr", cap_addr, 32'h20);
    check("sh_we", 32'(cap_we), 32'd1);
    check("sh_stall", 32'(stall_cyc), 32'd5);
    check("sh_wb_cnt", 32'(wb_cnt), 32'd0);

    // Misaligned LH and SW
    run_access(3'd2, 32'h0000_0013, 32'h0, 0);
    check("lh_mis_busy", 32'(busy_cyc), 32'd0);
    check("lh_mis_exc", 32'(exc_cnt), 32'd1);
    check("lh_mis_code", 32'(cap_code), 32'd1);
    check("lh_mis_bad", cap_bad, 32'h13);
    check("lh_mis_stall", 32'(stall_cyc), 32'd1);
    run_access(3'd5, 32'h0000_0006, 32'h5555_5555, 0);
    check("sw_mis_busy", 32'(busy_cyc), 32'd0);
    check("sw_mis_code", 32'(cap_code), 32'd2);
    check("sw_mis_bad", cap_bad, 32'h6);

    // LB 0x07, ack withheld -> timeout after 15 BUSY cycles
    run_access(3'd4, 32'h0000_0007, 32'h0, 1000);
    check("to_busy", 32'(busy_cyc), 32'd15);
    check("to_stall", 32'(stall_cyc), 32'd16);
    check("to_exc", 32'(exc_cnt), 32'd1);
    check("to_code", 32'(cap_code), 32'd3);
    check("to_bad", cap_bad, 32'h7);
    check("to_wb_cnt", 32'(wb_cnt), 32'd0);

    // LB 0x07, ack in the 15th BUSY cycle wins over the limit
    rdata_val = 32'hCAFE_F00D;
    run_access(3'd4, 32'h0000_0007, 32'h0, 14);
    check("ack15_busy", 32'(busy_cyc), 32'd15);
    check("ack15_exc", 32'(exc_cnt), 32'd0);
    check("ack15_wb_cnt", 32'(wb_cnt), 32'd1);
    check("ack15_kuo", 32'(cap_kuo), 32'd4);
    check("ack15_a", 32'(cap_a), 32'd3);
    check("ack15_data", cap_wb_data, 32'hCAFE_F00D);

    // SB 0x41 then LBU 0x42 back-to-back
    run_access(3'd7, 32'h0000_0041, 32'h0000_00A5, 1);
    check("sb_be", 32'(cap_be), 32'h2);
    check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    check("sb_addr", cap_addr, 32'h40);
    rdata_val = 32'h1122_3344;
    run_access(3'd3, 32'h0000_0042, 32'h0, 0);
    check("lbu_be", 32'(cap_be), 32'hF);
    check("lbu_kuo", 32'(cap_kuo), 32'd3);
    check("lbu_a", 32'(cap_a), 32'd2);
    check("lbu_data", cap_wb_data, 32'h1122_3344);

    // Reset during BUSY, then a stray ack
    ack_wait      = 1000;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd0;
    bus.req_addr  = 32'h0000_0100;
    repeat (3) @(negedge clk);
    check("mid_mem_req", 32'(bus.mem_req), 32'd1);
    check("mid_stall", 32'(bus.stall), 32'd1);
    #1;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mid_stall", 32'(bus.stall), 32'd0);
    check("rst_mid_wb_data", bus.wb_data, 32'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    ack_force = 1'b1;
    @(posedge clk); #1;
    ack_force = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_ack_wb", 32'(bus.wb_valid), 32'd0);
      check("late_ack_req", 32'(bus.mem_req), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Sequencer for data-memory accesses issued by the MEM stage of the pipelined MIPS CPU. It checks alignment, drives a data memory port with wait-state handshake, generates store byte enables and lane-replicated write data, and stalls the pipeline until the access completes. For loads it hands the raw word to the WB-stage byte/half extension unit, together with the extension code and the low address bits that configure that unit. It raises address-error and bus-timeout exceptions.

## Interface
- WAIT_MAX, 15: maximum BUSY cycles without `mem_ack` before a timeout fault; legal range 1..255.
- clk  in  1  system clock; every register updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage holds a load or store.
- req_op  in  3  access type: 0 LW, 1 LHU, 2 LH, 3 LBU, 4 LB, 5 SW, 6 SH, 7 SB.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data from rt.
- stall  out  1  freezes PC/IF/ID/EX/MEM.
- mem_req  out  1  memory request valid.
- mem_we  out  1  write request.
- mem_addr  out  32  word address, with {req_addr[31:2],2'b00}.
- mem_be  out  4  byte enables; bit i selects bits [8i+7:8i].
- mem_wdata  out  32  lane-replicated write data.
- mem_ack  in  1  memory has completed the current request.
- mem_rdata  in  32  read word; valid while `mem_ack` is high.
- wb_valid  out  1  one-cycle pulse when load data is ready.
- wb_data  out  32  raw read word; held until the next load completes.
- wb_a  out  2  req_addr[1:0] of that load; drives extension unit A.
- wb_kuo  out  4  extension code: 0 word, 1 zero-ext half, 2 sign-ext half, 3 zero-ext byte, 4 sign-ext byte.
- exc_valid  out  1  one-cycle exception pulse.
- exc_code  out  2  0 none, 1 AdEL, 2 AdES, 3 bus timeout.
- bad_addr  out  32  faulting byte address.

## Operation
- States:
  - IDLE, BUSY, RESP, FAULT.
- IDLE:
  - If `req_valid` is low, stay in IDLE.
  - If `req_valid` is high and the address is misaligned, latch `bad_addr` and go to FAULT. The exception code is AdEL for loads and AdES for stores.
  - If `req_valid` is high and the address is aligned, latch address, op, byte enables and write data, then go to BUSY.
- Alignment rules:
  - LW/SW need addr[1:0]==0.
  - LH/LHU/SH need addr[0]==0.
  - Byte ops are always aligned.
- Byte enables:
  - SW: 1111.
  - SH: 0011 if a[1]==0, else 1100.
  - SB: 0001<<a.
  - Loads: 1111.
- Write data:
  - SW: wdata.
  - SH: {2{wdata[15:0]}}.
  - SB: {4{wdata[7:0]}}.
- BUSY:
  - `mem_req`=1 and `mem_we`=store.
  - `mem_addr`, `mem_be` and `mem_wdata` stay stable until `mem_ack`.
  - On `mem_ack`, go to RESP. For a load, `wb_data`<=`mem_rdata` and latch `wb_a`/`wb_kuo`.
  - The wait counter increments each BUSY cycle without ack. If it reaches WAIT_MAX with no ack, latch `bad_addr`, set code 3 and go to FAULT.
  - If ack arrives in the same cycle the limit is reached, the ack wins.
- RESP:
  - `wb_valid`=1 for loads, 0 for stores.
  - Return to IDLE.
- FAULT:
  - `exc_valid`=1 with the latched code.
  - Return to IDLE. No memory access is issued for misaligned addresses.
- stall = (IDLE & req_valid) | BUSY. Stall is low in RESP and FAULT, so the instruction retires or traps at the end of that cycle.
- `mem_ack` outside BUSY is ignored.
- Reset:
  - Asynchronous; state goes to IDLE.
  - All outputs and registers return to 0, including the counter and `wb_data`.
  - Asserting reset mid-BUSY drops `mem_req` immediately; a late `mem_ack` is ignored.

## Timing
- Aligned access with zero wait:
  - Cycle 0 is IDLE (stall=1).
  - Cycle 1 is BUSY with `mem_ack`.
  - Cycle 2 is RESP (stall=0, `wb_valid`).
  - Two stall cycles in total.
- Each wait state adds one BUSY cycle.
- Misaligned access:
  - Cycle 0 is IDLE (stall=1).
  - Cycle 1 is FAULT (`exc_valid`, stall=0).
- Timeout: FAULT follows the BUSY cycle in which the counter reaches WAIT_MAX.
- Back-to-back requests: IDLE re-samples `req_valid` the cycle after RESP/FAULT. There is no pipelining of accesses.
- `wb_valid`/`exc_valid` are registered outputs, never asserted together.

## Structure
- Package dm_pkg holds:
  - op codes;
  - extension (kuo) codes;
  - exception codes;
  - state encoding.
- Sub-module dm_lane_gen is combinational. From op and addr[1:0] it produces the misaligned flag, byte enables and replicated write data. It is instantiated once, feeding the IDLE latch.
- The top module holds the FSM, the wait counter and the output registers.

## Test plan
- LW 0x0000_0010, ack in first BUSY cycle, rdata 0xDEAD_BEEF -> stall high 2 cycles, `wb_valid` pulse, wb_data 0xDEADBEEF, wb_kuo 0, wb_a 0.
- SH addr 0x22, wdata 0x1234_ABCD, ack after 3 waits -> mem_be 1100, mem_wdata 0xABCD_ABCD, mem_addr 0x20, stall 5 cycles, no `wb_valid`.
- LH addr 0x13 -> no `mem_req`, exc_valid, exc_code 1, bad_addr 0x13. SW addr 0x06 -> exc_code 2.
- LB addr 0x07, ack withheld, WAIT_MAX=15 -> FAULT after 15 BUSY cycles, exc_code 3. Ack on cycle 15 instead -> normal RESP with wb_kuo 4, wb_a 3.
- Reset asserted during BUSY -> `mem_req`/stall fall immediately. After release, an ack pulse produces no `wb_valid`.
- SB addr 0x41 then LBU addr 0x42 back-to-back -> mem_be 0010 then 1111, wb_kuo 3, wb_a 2.
